glb_sram_responder: RTL and testbench

//  Synthesizable global-buffer (GLB) responder: the memory end of the tiling engine's glb_re/glb_we port.

---
 rtl/glb_sram_responder_pkg.sv | 32 +++
 rtl/glb_sram_responder_if.sv | 27 ++
 rtl/glb_byte_bank.sv | 24 ++
 rtl/glb_sram_responder.sv | 143 ++++++++++++++
 tb/tb_glb_sram_responder.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/glb_sram_responder_pkg.sv
// Shared types and helpers for the GLB responder: lane-mask type, legal masks,
// error-bit indices and mask decode functions.
package glb_pkg;

  typedef logic [3:0] glb_mask_t;

  localparam glb_mask_t MASK_B1 = 4'b0001;
  localparam glb_mask_t MASK_B2 = 4'b0011;
  localparam glb_mask_t MASK_B3 = 4'b0111;
  localparam glb_mask_t MASK_B4 = 4'b1111;

  typedef enum logic {
    ERR_MASK  = 1'b0,
    ERR_RANGE = 1'b1
  } glb_err_e;

  function automatic logic mask_legal(input glb_mask_t m);
    return (m == '0) || (m == MASK_B1) || (m == MASK_B2) ||
           (m == MASK_B3) || (m == MASK_B4);
  endfunction

  function automatic logic [2:0] mask_len(input glb_mask_t m);
    case (m)
      MASK_B1: return 3'd1;
      MASK_B2: return 3'd2;
      MASK_B3: return 3'd3;
      MASK_B4: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/glb_sram_responder_if.sv
// GLB read/write port between the tiling engine (master) and the responder (slave).
interface glb_sram_responder_if
  import glb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 8
);

  glb_mask_t                   glb_re;
  logic [ADDR_WIDTH-1:0]       glb_r_addr;
  logic [DATA_WIDTH*4-1:0]     glb_r_data;
  logic                        glb_r_valid;
  glb_mask_t                   glb_we;
  logic [ADDR_WIDTH-1:0]       glb_w_addr;
  logic [DATA_WIDTH*4-1:0]     glb_w_data;

  modport master (
    output glb_re, glb_r_addr, glb_we, glb_w_addr, glb_w_data,
    input  glb_r_data, glb_r_valid
  );

  modport slave (
    input  glb_re, glb_r_addr, glb_we, glb_w_addr, glb_w_data,
    output glb_r_data, glb_r_valid
  );

endinterface

// File: rtl/glb_byte_bank.sv
// One byte-wide 1R1W SRAM bank with synchronous read; a same-row read and write
// in one cycle returns the pre-write contents.
module glb_byte_bank #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ROWS       = 4096,
  localparam int unsigned ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ROW_W-1:0]      w_row,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  re,
  input  logic [ROW_W-1:0]      r_row,
  output logic [DATA_WIDTH-1:0] r_data
);

  logic [DATA_WIDTH-1:0] mem [ROWS];

  always_ff @(posedge clk) begin
    if (we) mem[w_row] <= w_data;
    if (re) r_data <= mem[r_row];
  end

endmodule

// File: rtl/glb_sram_responder.sv
// GLB responder: 4 interleaved byte banks behind a byte-addressed 1R1W port with
// lane rotation, mask/range checking and counters. Option macro: GLB_RW_FWD_EN.
module glb_sram_responder
  import glb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16384
) (
  input  logic                 clk,
  input  logic                 rst,
  glb_sram_responder_if.slave  bus,
  output logic [1:0]           err,
  input  logic                 err_clr,
  output logic [31:0]          rd_cnt,
  output logic [31:0]          wr_cnt
);

  localparam int unsigned ROWS  = DEPTH / 4;
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned EXT_W = ADDR_WIDTH + 2;
  localparam int unsigned DW    = DATA_WIDTH;

  glb_mask_t        re_m, we_m;
  logic [EXT_W-1:0] r_base, w_base, r_last, w_last;
  logic             re_legal, we_legal, re_oob, we_oob, rd_go, wr_go;

  // Range check is done in a widened domain so addresses near 2^ADDR_WIDTH cannot wrap.
  always_comb begin
    re_m     = bus.glb_re;
    we_m     = bus.glb_we;
    r_base   = EXT_W'(bus.glb_r_addr);
    w_base   = EXT_W'(bus.glb_w_addr);
    r_last   = r_base + EXT_W'(mask_len(re_m)) - EXT_W'(1);
    w_last   = w_base + EXT_W'(mask_len(we_m)) - EXT_W'(1);
    re_legal = mask_legal(re_m);
    we_legal = mask_legal(we_m);
    re_oob   = re_legal && (re_m != '0) && (r_last >= EXT_W'(DEPTH));
    we_oob   = we_legal && (we_m != '0) && (w_last >= EXT_W'(DEPTH));
    rd_go    = re_legal && (re_m != '0) && !re_oob;
    wr_go    = we_legal && (we_m != '0) && !we_oob;
  end

  logic [1:0]       r_k [4];
  logic [1:0]       w_k [4];
  logic [ROW_W-1:0] r_row [4];
  logic [ROW_W-1:0] w_row [4];
  logic [DW-1:0]    bank_wd [4];
  logic [DW-1:0]    bank_rd [4];
  logic [3:0]       bank_re, bank_we;

  // Bank b serves lane k = (b - addr[1:0]) mod 4 at row (addr + k) >> 2.
  always_comb begin
    for (int unsigned b = 0; b < 4; b++) begin
      r_k[b]     = 2'(b) - bus.glb_r_addr[1:0];
      w_k[b]     = 2'(b) - bus.glb_w_addr[1:0];
      r_row[b]   = ROW_W'((r_base + EXT_W'(r_k[b])) >> 2);
      w_row[b]   = ROW_W'((w_base + EXT_W'(w_k[b])) >> 2);
      bank_re[b] = rd_go && re_m[r_k[b]];
      bank_we[b] = wr_go && we_m[w_k[b]];
      bank_wd[b] = bus.glb_w_data[w_k[b]*DW +: DW];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_bank
    glb_byte_bank #(
      .DATA_WIDTH (DW),
      .ROWS       (ROWS)
    ) u_bank (
      .clk    (clk),
      .we     (bank_we[g]),
      .w_row  (w_row[g]),
      .w_data (bank_wd[g]),
      .re     (bank_re[g]),
      .r_row  (r_row[g]),
      .r_data (bank_rd[g])
    );
  end

`ifdef GLB_RW_FWD_EN
  logic [3:0]    fwd_hit_q;
  logic [DW-1:0] fwd_data_q [4];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_hit_q <= '0;
      for (int unsigned b = 0; b < 4; b++) fwd_data_q[b] <= '0;
    end else begin
      for (int unsigned b = 0; b < 4; b++) begin
        fwd_hit_q[b]  <= bank_re[b] && bank_we[b] && (r_row[b] == w_row[b]);
        fwd_data_q[b] <= bank_wd[b];
      end
    end
  end
`endif

  glb_mask_t     rd_mask_q;
  logic [1:0]    rd_off_q;
  logic [1:0]    lane_sel;
  logic [DW-1:0] bank_byte [4];

  // Zeroing rd_mask_q on reset or a rejected read blanks the data without touching the banks.
  always_comb begin
    lane_sel = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      bank_byte[b] = bank_rd[b];
`ifdef GLB_RW_FWD_EN
      if (fwd_hit_q[b]) bank_byte[b] = fwd_data_q[b];
`endif
    end
    bus.glb_r_data = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      lane_sel = 2'(k) + rd_off_q;
      if (rd_mask_q[k]) bus.glb_r_data[k*DW +: DW] = bank_byte[lane_sel];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_mask_q       <= '0;
      rd_off_q        <= '0;
      bus.glb_r_valid <= 1'b0;
      err             <= '0;
      rd_cnt          <= '0;
      wr_cnt          <= '0;
    end else begin
      rd_mask_q       <= rd_go ? re_m : '0;
      rd_off_q        <= bus.glb_r_addr[1:0];
      bus.glb_r_valid <= rd_go;
      if (err_clr) begin
        err    <= '0;
        rd_cnt <= '0;
        wr_cnt <= '0;
      end else begin
        if (rd_go && (rd_cnt != '1)) rd_cnt <= rd_cnt + 32'd1;
        if (wr_go && (wr_cnt != '1)) wr_cnt <= wr_cnt + 32'd1;
      end
      if (!re_legal || !we_legal) err[ERR_MASK]  <= 1'b1;
      if (re_oob || we_oob)       err[ERR_RANGE] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_glb_sram_responder.sv
// Self-checking bench for glb_sram_responder against a flat byte-array model.
module tb_glb_sram_responder;

  localparam int unsigned DEPTH = 256;

  logic        clk;
  logic        rst;
  logic        err_clr;
  logic [1:0]  err;
  logic [31:0] rd_cnt, wr_cnt;

  glb_sram_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(8)) bus_if ();

  glb_sram_responder #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (8),
    .DEPTH      (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_if),
    .err     (err),
    .err_clr (err_clr),
    .rd_cnt  (rd_cnt),
    .wr_cnt  (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mem_m [DEPTH];
  logic [31:0] exp_rdata;
  logic        exp_rvalid;
  logic [1:0]  exp_err;
  logic [31:0] exp_rd, exp_wr;
  int unsigned n_checks, n_fail;

  function automatic bit legal(input logic [3:0] m);
    return m inside {4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
  endfunction

  function automatic logic [3:0] rand_mask();
    logic [3:0] tbl [5];
    tbl = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0000};
    if ($urandom_range(0, 9) == 0) return 4'($urandom);
    return tbl[$urandom_range(0, 4)];
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return 32'(DEPTH - 4 + $urandom_range(0, 3));
      1:       return 32'(DEPTH + $urandom_range(0, 8));
      2:       return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      default: return 32'($urandom_range(0, DEPTH - 1));
    endcase
  endfunction

  // One clock of stimulus; the model predicts the outputs seen just after that edge.
  task automatic issue(input logic [3:0] re, input logic [31:0] ra, input logic [3:0] we,
                       input logic [31:0] wa, input logic [31:0] wd, input logic clr);
    bit          r_ok, w_ok;
    logic [1:0]  new_err;
    logic [31:0] rbytes;
    int unsigned rn, wn;
    bus_if.glb_re = re; bus_if.glb_r_addr = ra;
    bus_if.glb_we = we; bus_if.glb_w_addr = wa; bus_if.glb_w_data = wd;
    err_clr = clr;
    rn = $countones(re); wn = $countones(we);
    new_err = '0; r_ok = 0; w_ok = 0;
    if (re != 0) begin
      if (!legal(re)) new_err[0] = 1'b1;
      else if (longint'(ra) + longint'(rn) - 1 >= longint'(DEPTH)) new_err[1] = 1'b1;
      else r_ok = 1;
    end
    if (we != 0) begin
      if (!legal(we)) new_err[0] = 1'b1;
      else if (longint'(wa) + longint'(wn) - 1 >= longint'(DEPTH)) new_err[1] = 1'b1;
      else w_ok = 1;
    end
    rbytes = '0;
`ifdef GLB_RW_FWD_EN
    if (w_ok) for (int i = 0; i < int'(wn); i++) mem_m[wa + 32'(i)] = wd[8*i +: 8];
    if (r_ok) for (int i = 0; i < int'(rn); i++) rbytes[8*i +: 8] = mem_m[ra + 32'(i)];
`else
    if (r_ok) for (int i = 0; i < int'(rn); i++) rbytes[8*i +: 8] = mem_m[ra + 32'(i)];
    if (w_ok) for (int i = 0; i < int'(wn); i++) mem_m[wa + 32'(i)] = wd[8*i +: 8];
`endif
    exp_rdata  = rbytes;
    exp_rvalid = r_ok;
    if (clr) begin
      exp_err = '0; exp_rd = '0; exp_wr = '0;
    end else begin
      if (r_ok && exp_rd != '1) exp_rd++;
      if (w_ok && exp_wr != '1) exp_wr++;
    end
    exp_err |= new_err;
    @(posedge clk); #1;
    bus_if.glb_re = '0; bus_if.glb_we = '0; err_clr = 1'b0;
  endtask

  task automatic idle();
    issue(4'b0000, '0, 4'b0000, '0, '0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0; err_clr = 1'b0;
    bus_if.glb_re = '0; bus_if.glb_we = '0;
    bus_if.glb_r_addr = '0; bus_if.glb_w_addr = '0; bus_if.glb_w_data = '0;
    exp_rdata = '0; exp_rvalid = 1'b0; exp_err = '0; exp_rd = '0; exp_wr = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus_if.glb_r_data, bus_if.glb_r_valid, err, rd_cnt, wr_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: rdata=%h rvalid=%b err=%b rd=%0d wr=%0d, required all zero",
               bus_if.glb_r_data, bus_if.glb_r_valid, err, rd_cnt, wr_cnt);
    end
    rst = 1'b1;
    for (int a = 0; a < int'(DEPTH); a += 4) issue(4'b0000, '0, 4'b1111, 32'(a), $urandom, 1'b0);
  endtask

  task automatic test_write_read();
    issue(4'b0000, '0, 4'b1111, 32'd8, 32'h4433_2211, 1'b0);
    issue(4'b1111, 32'd8, 4'b0000, '0, '0, 1'b0);
    n_checks++;
    if (bus_if.glb_r_data !== 32'h4433_2211 || bus_if.glb_r_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL aligned_read: rdata=%h rvalid=%b, required 44332211/1",
               bus_if.glb_r_data, bus_if.glb_r_valid);
    end
    idle();
    n_checks++;
    if (bus_if.glb_r_data !== '0 || bus_if.glb_r_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_clears: rdata=%h rvalid=%b, required 0/0", bus_if.glb_r_data, bus_if.glb_r_valid);
    end
  endtask

  task automatic test_row_span();
    issue(4'b0000, '0, 4'b1111, 32'd6, 32'hDDCC_BBAA, 1'b0);
    issue(4'b0011, 32'd7, 4'b0000, '0, '0, 1'b0);
    n_checks++;
    if (bus_if.glb_r_data !== 32'h0000_CCBB || bus_if.glb_r_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL row_span: rdata=%h rvalid=%b, required 0000ccbb/1", bus_if.glb_r_data, bus_if.glb_r_valid);
    end
    for (int i = 0; i < 4; i++) begin
      issue(4'b0111, 32'(5 + i), 4'b0000, '0, '0, 1'b0);
      n_checks++;
      if (bus_if.glb_r_data !== exp_rdata) begin
        n_fail++;
        $display("FAIL span3_%0d: rdata=%h, required %h", i, bus_if.glb_r_data, exp_rdata);
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] want;
`ifdef GLB_RW_FWD_EN
    want = 32'h0000_0099;
`else
    want = 32'h0000_0011;
`endif
    issue(4'b0000, '0, 4'b0001, 32'd20, 32'h11, 1'b0);
    issue(4'b0001, 32'd20, 4'b0001, 32'd20, 32'h99, 1'b0);
    n_checks++;
    if (bus_if.glb_r_data !== want) begin
      n_fail++;
      $display("FAIL same_cycle_rw: rdata=%h, required %h", bus_if.glb_r_data, want);
    end
    issue(4'b0001, 32'd20, 4'b0000, '0, '0, 1'b0);
    n_checks++;
    if (bus_if.glb_r_data !== 32'h99) begin
      n_fail++;
      $display("FAIL after_rw: rdata=%h, required 00000099", bus_if.glb_r_data);
    end
  endtask

  task automatic test_illegal_mask();
    issue(4'b0000, '0, 4'b0000, '0, '0, 1'b1);
    issue(4'b0000, '0, 4'b0101, 32'd0, 32'hFFFF_FFFF, 1'b0);
    n_checks++;
    if (err !== 2'b01 || wr_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL illegal_write: err=%b wr_cnt=%0d, required 01/0", err, wr_cnt);
    end
    issue(4'b0110, 32'd0, 4'b0000, '0, '0, 1'b0);
    n_checks++;
    if (bus_if.glb_r_data !== '0 || bus_if.glb_r_valid !== 1'b0 || rd_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL illegal_read: rdata=%h rvalid=%b rd_cnt=%0d, required 0/0/0",
               bus_if.glb_r_data, bus_if.glb_r_valid, rd_cnt);
    end
    issue(4'b1111, 32'd0, 4'b0000, '0, '0, 1'b0);
    n_checks++;
    if (bus_if.glb_r_data !== exp_rdata) begin
      n_fail++;
      $display("FAIL mem_untouched: rdata=%h, required %h", bus_if.glb_r_data, exp_rdata);
    end
    issue(4'b0000, '0, 4'b0000, '0, '0, 1'b1);
    n_checks++;
    if ({err, rd_cnt, wr_cnt} !== '0) begin
      n_fail++;
      $display("FAIL err_clr: err=%b rd=%0d wr=%0d, required zeros", err, rd_cnt, wr_cnt);
    end
    issue(4'b1001, 32'd0, 4'b0000, '0, '0, 1'b1);
    n_checks++;
    if (err !== 2'b01) begin
      n_fail++;
      $display("FAIL clr_set_wins: err=%b, required 01", err);
    end
  endtask

  task automatic test_out_of_range();
    issue(4'b0000, '0, 4'b0000, '0, '0, 1'b1);
    issue(4'b1111, 32'(DEPTH - 2), 4'b0000, '0, '0, 1'b0);
    n_checks++;
    if (bus_if.glb_r_data !== '0 || bus_if.glb_r_valid !== 1'b0 || err !== 2'b10) begin
      n_fail++;
      $display("FAIL oob_read: rdata=%h rvalid=%b err=%b, required 0/0/10",
               bus_if.glb_r_data, bus_if.glb_r_valid, err);
    end
    issue(4'b0000, '0, 4'b0011, 32'(DEPTH - 1), 32'h0000_A5A5, 1'b0);
    issue(4'b0001, 32'(DEPTH - 1), 4'b0000, '0, '0, 1'b0);
    n_checks++;
    if (bus_if.glb_r_data !== exp_rdata || bus_if.glb_r_valid !== 1'b1 || wr_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL oob_write: rdata=%h rvalid=%b wr=%0d, required %h/1/0",
               bus_if.glb_r_data, bus_if.glb_r_valid, wr_cnt, exp_rdata);
    end
    issue(4'b1111, 32'(DEPTH - 4), 4'b0000, '0, '0, 1'b0);
    n_checks++;
    if (bus_if.glb_r_data !== exp_rdata || bus_if.glb_r_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL top_edge_read: rdata=%h rvalid=%b, required %h/1",
               bus_if.glb_r_data, bus_if.glb_r_valid, exp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      issue(4'b1111, 32'($urandom_range(0, 40)), 4'b1111, 32'($urandom_range(0, 40)), $urandom, 1'b0);
      n_checks++;
      if ({bus_if.glb_r_data, bus_if.glb_r_valid, err, rd_cnt, wr_cnt} !==
          {exp_rdata, exp_rvalid, exp_err, exp_rd, exp_wr}) begin
        n_fail++;
        $display("FAIL b2b_%0d: rdata=%h rv=%b err=%b rd=%0d wr=%0d, required %h/%b/%b/%0d/%0d",
                 i, bus_if.glb_r_data, bus_if.glb_r_valid, err, rd_cnt, wr_cnt,
                 exp_rdata, exp_rvalid, exp_err, exp_rd, exp_wr);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) issue(4'b0000, '0, 4'b0000, '0, '0, 1'b1);
      else issue(rand_mask(), rand_addr(), rand_mask(), rand_addr(), $urandom, 1'b0);
      n_checks++;
      if ({bus_if.glb_r_data, bus_if.glb_r_valid, err, rd_cnt, wr_cnt} !==
          {exp_rdata, exp_rvalid, exp_err, exp_rd, exp_wr}) begin
        n_fail++;
        $display("FAIL rand_%0d: rdata=%h rv=%b err=%b rd=%0d wr=%0d, required %h/%b/%b/%0d/%0d",
                 i, bus_if.glb_r_data, bus_if.glb_r_valid, err, rd_cnt, wr_cnt,
                 exp_rdata, exp_rvalid, exp_err, exp_rd, exp_wr);
      end
    end
  endtask

  task automatic test_reset_mid();
    issue(4'b1111, 32'd8, 4'b0000, '0, '0, 1'b0);
    n_checks++;
    if (bus_if.glb_r_valid !== 1'b1 || bus_if.glb_r_data !== exp_rdata) begin
      n_fail++;
      $display("FAIL pre_reset_read: rvalid=%b rdata=%h, required 1/%h",
               bus_if.glb_r_valid, bus_if.glb_r_data, exp_rdata);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus_if.glb_r_data, bus_if.glb_r_valid, err, rd_cnt, wr_cnt} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: rdata=%h rvalid=%b err=%b rd=%0d wr=%0d, required all zero",
               bus_if.glb_r_data, bus_if.glb_r_valid, err, rd_cnt, wr_cnt);
    end
    exp_err = '0; exp_rd = '0; exp_wr = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    issue(4'b1111, 32'd8, 4'b0000, '0, '0, 1'b0);
    n_checks++;
    if (bus_if.glb_r_data !== exp_rdata || bus_if.glb_r_valid !== 1'b1 || rd_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL post_reset_read: rdata=%h rvalid=%b rd=%0d, required %h/1/1",
               bus_if.glb_r_data, bus_if.glb_r_valid, rd_cnt, exp_rdata);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_write_read();
    test_row_span();
    test_same_cycle();
    test_illegal_mask();
    test_out_of_range();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
